// File: rtl/actuated_traffic_light_controller_pkg.sv
// Shared definitions for the actuated traffic light controller: state codes,
// lamp patterns and the lamp decode helper.
package actuated_traffic_light_controller_pkg;

    typedef enum logic [2:0] {
        ST_NS_G  = 3'd0,
        ST_NS_Y  = 3'd1,
        ST_AR1   = 3'd2,
        ST_EW_G  = 3'd3,
        ST_EW_Y  = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } tlc_state_t;

    // Per-road lamp pattern, ordered {red, yellow, green}
    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Returns {ns[2:0], ew[2:0]}; unknown codes decode to all-red as the safe pattern
    function automatic logic [5:0] lamp_decode(input logic [2:0] st, input logic flash_dark);
        logic [5:0] lamps;
        case (st)
            3'd0:    lamps = {LAMP_GREEN, LAMP_RED};
            3'd1:    lamps = {LAMP_YELLOW, LAMP_RED};
            3'd2:    lamps = {LAMP_RED, LAMP_RED};
            3'd3:    lamps = {LAMP_RED, LAMP_GREEN};
            3'd4:    lamps = {LAMP_RED, LAMP_YELLOW};
            3'd5:    lamps = {LAMP_RED, LAMP_RED};
            3'd6: begin
                if (flash_dark) begin
                    lamps = {LAMP_OFF, LAMP_OFF};
                end else begin
                    lamps = {LAMP_YELLOW, LAMP_RED};
                end
            end
            default: lamps = {LAMP_RED, LAMP_RED};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/actuated_traffic_light_controller_sat_timer.sv
// Saturating up-counter: clr wins over en, and the count sticks at all-ones.
module actuated_traffic_light_controller_sat_timer #(
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [CWIDTH-1:0] count
);

    // Count register with synchronous reset, clear and saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CWIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/actuated_traffic_light_controller.sv
// Sensor-actuated two-road intersection controller: NS rests on green, EW green
// is demand-driven and gap-extended up to a cap, with all-red clearance and flash mode.
module actuated_traffic_light_controller
    import actuated_traffic_light_controller_pkg::*;
#(
    parameter int CWIDTH      = 16,
    parameter int MIN_GREEN   = 3000,
    parameter int MAX_GREEN   = 9000,
    parameter int EXT_TIME    = 500,
    parameter int YELLOW_TIME = 500,
    parameter int ALLRED_TIME = 100,
    parameter int FLASH_HALF  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       flash,
    output logic       NS_Red,
    output logic       NS_Yellow,
    output logic       NS_Green,
    output logic       EW_Red,
    output logic       EW_Yellow,
    output logic       EW_Green,
    output logic [2:0] phase,
    output logic       req_pending
);

    localparam logic [CWIDTH-1:0] MIN_GREEN_M1   = CWIDTH'(MIN_GREEN - 1);
    localparam logic [CWIDTH-1:0] MAX_GREEN_M1   = CWIDTH'(MAX_GREEN - 1);
    localparam logic [CWIDTH-1:0] EXT_TIME_M1    = CWIDTH'(EXT_TIME - 1);
    localparam logic [CWIDTH-1:0] YELLOW_TIME_M1 = CWIDTH'(YELLOW_TIME - 1);
    localparam logic [CWIDTH-1:0] ALLRED_TIME_M1 = CWIDTH'(ALLRED_TIME - 1);
    localparam logic [CWIDTH-1:0] FLASH_HALF_M1  = CWIDTH'(FLASH_HALF - 1);

    // Plain vector so an out-of-range code is representable and recoverable
    logic [2:0]        state_r;
    tlc_state_t        next_state_s;
    logic              req_r;
    logic              flash_dark_r;
    logic [CWIDTH-1:0] flash_cnt_r;
    logic [CWIDTH-1:0] cnt_s;
    logic [CWIDTH-1:0] gap_s;
    logic              state_change_s;
    logic              ew_g_entry_s;
    logic              gap_clr_s;
    logic [5:0]        lamps_s;

    assign state_change_s = (next_state_s != state_r);
    assign ew_g_entry_s   = (next_state_s == ST_EW_G) && (state_r != ST_EW_G);
    assign gap_clr_s      = ew_g_entry_s || ((state_r == ST_EW_G) && sensor);

    actuated_traffic_light_controller_sat_timer #(.CWIDTH(CWIDTH)) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_change_s),
        .en    (1'b1),
        .count (cnt_s)
    );

    actuated_traffic_light_controller_sat_timer #(.CWIDTH(CWIDTH)) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (gap_clr_s),
        .en    (state_r == ST_EW_G),
        .count (gap_s)
    );

    // Next-state selection; flash overrides every normal transition
    always_comb begin
        next_state_s = ST_NS_G;
        if (flash) begin
            next_state_s = ST_FLASH;
        end else begin
            case (state_r)
                ST_NS_G: begin
                    if (req_r && (cnt_s >= MIN_GREEN_M1)) next_state_s = ST_NS_Y;
                    else                                  next_state_s = ST_NS_G;
                end
                ST_NS_Y: begin
                    if (cnt_s == YELLOW_TIME_M1) next_state_s = ST_AR1;
                    else                         next_state_s = ST_NS_Y;
                end
                ST_AR1: begin
                    if (cnt_s == ALLRED_TIME_M1) next_state_s = ST_EW_G;
                    else                         next_state_s = ST_AR1;
                end
                ST_EW_G: begin
                    if (((cnt_s >= MIN_GREEN_M1) && (gap_s >= EXT_TIME_M1)) ||
                        (cnt_s >= MAX_GREEN_M1)) next_state_s = ST_EW_Y;
                    else                         next_state_s = ST_EW_G;
                end
                ST_EW_Y: begin
                    if (cnt_s == YELLOW_TIME_M1) next_state_s = ST_AR2;
                    else                         next_state_s = ST_EW_Y;
                end
                ST_AR2: begin
                    if (cnt_s == ALLRED_TIME_M1) next_state_s = ST_NS_G;
                    else                         next_state_s = ST_AR2;
                end
                ST_FLASH: next_state_s = ST_AR2;
                default:  next_state_s = ST_NS_G;
            endcase
        end
    end

    // State register, EW demand latch and flash blink toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_NS_G;
            req_r        <= 1'b0;
            flash_dark_r <= 1'b0;
            flash_cnt_r  <= '0;
        end else begin
            state_r <= next_state_s;
            // Entry to EW green consumes the demand, even if the sensor is still high
            if (ew_g_entry_s) begin
                req_r <= 1'b0;
            end else if (sensor && (state_r != ST_EW_G)) begin
                req_r <= 1'b1;
            end else begin
                req_r <= req_r;
            end
            if ((next_state_s == ST_FLASH) && (state_r != ST_FLASH)) begin
                flash_dark_r <= 1'b0;
                flash_cnt_r  <= '0;
            end else if (state_r == ST_FLASH) begin
                if (flash_cnt_r == FLASH_HALF_M1) begin
                    flash_cnt_r  <= '0;
                    flash_dark_r <= ~flash_dark_r;
                end else begin
                    flash_cnt_r  <= flash_cnt_r + CWIDTH'(1);
                    flash_dark_r <= flash_dark_r;
                end
            end else begin
                flash_dark_r <= flash_dark_r;
                flash_cnt_r  <= flash_cnt_r;
            end
        end
    end

    assign lamps_s = lamp_decode(state_r, flash_dark_r);
    assign {NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green} = lamps_s;
    assign phase       = state_r;
    assign req_pending = req_r;

endmodule
